spi_master_ctrl: RTL and testbench

Byte-level SPI master sequencer sitting directly upstream of `shift_register` in the SPI controller. It accepts a transmit byte over a valid/ready handshake and loads it into the shift register. It then generates SCLK (mode 0: CPOL=0, CPHA=0) and chip-select, and issues the per-bit `i_slow_clk` shift pulses. When the transfer is done it reads back the received byte and presents it with a one-cycle valid pulse.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_clk_gen.sv | 34 +++
 rtl/spi_master_ctrl.sv | 170 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer.
package spi_pkg;

   localparam int SPI_WIDTH = 8;

   typedef enum logic [1:0] {
      SR_HOLD  = 2'b00,
      SR_RIGHT = 2'b01,
      SR_LEFT  = 2'b10,
      SR_LOAD  = 2'b11
   } sr_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETUP,
      ST_SHIFT,
      ST_READ,
      ST_DONE,
      ST_HOLD
   } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period divider: o_tick marks the last i_clk cycle of each CLK_DIV-cycle period.
module spi_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Counter restarts from zero whenever the divider is disabled, so every phase starts aligned.
   always_comb begin
      cnt_d = '0;
      if (i_en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = i_en && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// Byte-level SPI master sequencer (mode 0) driving an external shift register.
// Define SPI_BURST_EN to allow back-to-back bytes under a single chip select.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [SPI_WIDTH-1:0] i_tx_data,
   input  logic                 i_tx_valid,
   output logic                 o_tx_ready,
   input  logic                 i_lsb_first,
   output logic [SPI_WIDTH-1:0] o_rx_data,
   output logic                 o_rx_valid,
   output logic                 o_busy,
   output logic                 o_sclk,
   output logic                 o_cs_n,
   output logic [1:0]           o_sr_mode,
   output logic                 o_sr_slow_clk,
   output logic                 o_sr_output_enable_n,
   output logic [SPI_WIDTH-1:0] o_sr_parallel,
   input  logic [SPI_WIDTH-1:0] i_sr_parallel
);

   spi_state_t           state_q, state_d;
   logic [3:0]           halfCnt_q, halfCnt_d;
   logic [SPI_WIDTH-1:0] txByte_q, rxData_q;
   logic                 lsbFirst_q, rxValid_q;
   logic                 sclk_q, sclk_d;
   logic                 csN_q, csN_d;
   logic                 slowClk_q, slowClk_d;
   logic                 oeN_q, oeN_d;
   sr_mode_t             srMode_q, srMode_d;
   logic                 txReady, accept, divEn, tick;

`ifdef SPI_BURST_EN
   logic burst_q;

   assign txReady = !i_rst && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Remembers that the current LOAD came straight from DONE, so SETUP is skipped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         burst_q <= 1'b0;
      end else if (accept) begin
         burst_q <= (state_q == ST_DONE);
      end
   end
`else
   assign txReady = !i_rst && (state_q == ST_IDLE);
`endif

   assign accept = i_tx_valid && txReady;
   assign divEn  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

   spi_clk_gen #(
      .CLK_DIV(CLK_DIV)
   ) uClkGen (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (divEn),
      .o_tick(tick)
   );

   // Half-period counter only runs in SHIFT and wraps back to zero on the 16th tick.
   always_comb begin
      state_d   = state_q;
      halfCnt_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_LOAD;
         end
         ST_LOAD: begin
`ifdef SPI_BURST_EN
            state_d = burst_q ? ST_SHIFT : ST_SETUP;
`else
            state_d = ST_SETUP;
`endif
         end
         ST_SETUP: begin
            if (tick) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            halfCnt_d = halfCnt_q;
            if (tick) begin
               halfCnt_d = halfCnt_q + 4'd1;
               if (halfCnt_q == 4'd15) state_d = ST_READ;
            end
         end
         ST_READ: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_HOLD;
`ifdef SPI_BURST_EN
            if (accept) state_d = ST_LOAD;
`endif
         end
         ST_HOLD: begin
            if (tick) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pin outputs are derived from the next state so they change on the same edge as the state.
   always_comb begin
      sclk_d    = (state_d == ST_SHIFT) && halfCnt_d[0];
      slowClk_d = (state_q == ST_SHIFT) && tick && !halfCnt_q[0];
      oeN_d     = (state_d != ST_READ);
      case (state_d)
         ST_IDLE: csN_d = 1'b1;
         ST_LOAD: csN_d = csN_q;
         default: csN_d = 1'b0;
      endcase
      srMode_d = SR_HOLD;
      if (state_d == ST_LOAD) begin
         srMode_d = SR_LOAD;
      end else if (state_d == ST_SHIFT) begin
         srMode_d = lsbFirst_q ? SR_RIGHT : SR_LEFT;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         halfCnt_q  <= '0;
         txByte_q   <= '0;
         lsbFirst_q <= 1'b0;
         rxData_q   <= '0;
         rxValid_q  <= 1'b0;
         sclk_q     <= 1'b0;
         csN_q      <= 1'b1;
         slowClk_q  <= 1'b0;
         oeN_q      <= 1'b1;
         srMode_q   <= SR_HOLD;
      end else begin
         state_q   <= state_d;
         halfCnt_q <= halfCnt_d;
         if (accept) begin
            txByte_q   <= i_tx_data;
            lsbFirst_q <= i_lsb_first;
         end
         if (state_q == ST_DONE) begin
            rxData_q <= i_sr_parallel;
         end
         rxValid_q <= (state_q == ST_DONE);
         sclk_q    <= sclk_d;
         csN_q     <= csN_d;
         slowClk_q <= slowClk_d;
         oeN_q     <= oeN_d;
         srMode_q  <= srMode_d;
      end
   end

   assign o_tx_ready           = txReady;
   assign o_busy               = (state_q != ST_IDLE);
   assign o_rx_data            = rxData_q;
   assign o_rx_valid           = rxValid_q;
   assign o_sclk               = sclk_q;
   assign o_cs_n               = csN_q;
   assign o_sr_mode            = srMode_q;
   assign o_sr_slow_clk        = slowClk_q;
   assign o_sr_output_enable_n = oeN_q;
   assign o_sr_parallel        = txByte_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: timeline model of each transfer plus a shift-register/MISO responder.
module tb_spi_master_ctrl;

   localparam int CD        = 4;
   localparam int SHIFT_LEN = 16 * CD;
`ifdef SPI_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] txData = 8'h00;
   logic       txValid = 1'b0;
   logic       lsbFirst = 1'b0;
   logic [7:0] srContents = 8'h00;

   logic       rdy, rxValidO, busyO, sclkO, csNO, slowO, oeNO;
   logic [7:0] rxDataO, parallelO;
   logic [1:0] modeO;

   spi_master_ctrl #(
      .CLK_DIV(CD)
   ) dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_tx_data           (txData),
      .i_tx_valid          (txValid),
      .o_tx_ready          (rdy),
      .i_lsb_first         (lsbFirst),
      .o_rx_data           (rxDataO),
      .o_rx_valid          (rxValidO),
      .o_busy              (busyO),
      .o_sclk              (sclkO),
      .o_cs_n              (csNO),
      .o_sr_mode           (modeO),
      .o_sr_slow_clk       (slowO),
      .o_sr_output_enable_n(oeNO),
      .o_sr_parallel       (parallelO),
      .i_sr_parallel       (srContents)
   );

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Shift-register neighbour: loads on mode 11, shifts on each strobe, MISO either loops MOSI or plays a pattern.
   bit         loopback = 1'b1;
   logic [7:0] misoPattern = 8'h00;
   logic [2:0] misoIdx = 3'd0;
   logic       mosiBit, misoBit;

   always_comb begin
      mosiBit = (modeO == 2'b01) ? srContents[0] : srContents[7];
      misoBit = mosiBit;
      if (!loopback) begin
         misoBit = (modeO == 2'b01) ? misoPattern[misoIdx] : misoPattern[3'd7 - misoIdx];
      end
   end

   always @(posedge clk) begin
      if (modeO == 2'b11) begin
         srContents <= parallelO;
         misoIdx    <= 3'd0;
      end else if (slowO && modeO == 2'b01) begin
         srContents <= {misoBit, srContents[7:1]};
         misoIdx    <= misoIdx + 3'd1;
      end else if (slowO && modeO == 2'b10) begin
         srContents <= {srContents[6:0], misoBit};
         misoIdx    <= misoIdx + 3'd1;
      end
   end

   // Observation counters used by the directed checks.
   logic prevSclk = 1'b0;
   logic mosiQ[$];
   int   slowPulses = 0, rxPulses = 0, loads = 0, csHighCycles = 0, lastRxCyc = 0;
   logic [7:0] lastRxData = 8'h00;

   always @(negedge clk) begin
      if (sclkO === 1'b1 && prevSclk === 1'b0) mosiQ.push_back(mosiBit);
      prevSclk <= sclkO;
      if (slowO === 1'b1) slowPulses <= slowPulses + 1;
      if (modeO === 2'b11) loads <= loads + 1;
      if (csNO === 1'b1) csHighCycles <= csHighCycles + 1;
      if (rxValidO === 1'b1) begin
         rxPulses   <= rxPulses + 1;
         lastRxCyc  <= cyc;
         lastRxData <= rxDataO;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: mK is the cycle index since the accept edge; mS is the SETUP length (0 for a burst byte).
   bit         mValid = 1'b0, mActive = 1'b0, mBurst = 1'b0, mLsb = 1'b0, mRxValid = 1'b0;
   int         mK = 0, mS = CD;
   logic [7:0] mTx = 8'h00, mExpRx = 8'h00, mRxData = 8'h00;

   task automatic modelStep();
      bit wasDone, ready;
      if (rst) begin
         mValid   = 1'b1;
         mActive  = 1'b0;
         mBurst   = 1'b0;
         mRxValid = 1'b0;
         mRxData  = 8'h00;
      end else if (mValid) begin
         wasDone  = mActive && (mK == mS + SHIFT_LEN + 2);
         ready    = !mActive || (BURST && wasDone);
         mRxValid = wasDone;
         if (wasDone) mRxData = mExpRx;
         if (txValid && ready) begin
            mBurst  = mActive;
            mActive = 1'b1;
            mK      = 0;
            mS      = mBurst ? 0 : CD;
            mTx     = txData;
            mLsb    = lsbFirst;
            mExpRx  = loopback ? txData : misoPattern;
         end else if (mActive) begin
            mK++;
            if (mK > mS + SHIFT_LEN + CD + 2) mActive = 1'b0;
         end
      end
   endtask

   task automatic checkModel();
      logic       eCs, eSclk, eSlow, eOe, eBusy, eRdy;
      logic [1:0] eMode;
      int         s, half;
      eCs = 1'b1; eSclk = 1'b0; eSlow = 1'b0; eOe = 1'b1; eBusy = 1'b0; eMode = 2'b00;
      if (mActive) begin
         eBusy = 1'b1;
         eCs   = 1'b0;
         if (mK == 0) begin
            eMode = 2'b11;
            eCs   = mBurst ? 1'b0 : 1'b1;
            checkOutput("sr_parallel", parallelO, mTx);
         end
         if (mK >= 1 + mS && mK <= mS + SHIFT_LEN) begin
            s     = mK - 1 - mS;
            half  = s / CD;
            eSclk = (half % 2 == 1);
            eSlow = (half % 2 == 1) && (s % CD == 0);
            eMode = mLsb ? 2'b01 : 2'b10;
         end
         if (mK == mS + SHIFT_LEN + 1) eOe = 1'b0;
      end
      eRdy = !rst && (!mActive || (BURST && mK == mS + SHIFT_LEN + 2));
      checkOutput("cs_n", csNO, eCs);
      checkOutput("sclk", sclkO, eSclk);
      checkOutput("slow_clk", slowO, eSlow);
      checkOutput("sr_mode", modeO, eMode);
      checkOutput("oe_n", oeNO, eOe);
      checkOutput("busy", busyO, eBusy);
      checkOutput("tx_ready", rdy, eRdy);
      checkOutput("rx_valid", rxValidO, mRxValid);
      checkOutput("rx_data", rxDataO, mRxData);
   endtask

   initial forever begin
      @(posedge clk);
      modelStep();
   end

   initial forever begin
      @(negedge clk);
      if (mValid) checkModel();
   end

   task automatic applyStimulus(input logic [7:0] d, input logic l, input bit keep, output int acc);
      bit found;
      @(posedge clk); #2;
      txData   = d;
      lsbFirst = l;
      txValid  = 1'b1;
      found    = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (rdy === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("accept timeout", found, 1);
      @(posedge clk); #2;
      acc = cyc;
      if (!keep) txValid = 1'b0;
   endtask

   task automatic waitRx(input int target, input int limit);
      for (int n = 0; n < limit && rxPulses < target; n++) @(posedge clk);
      checkOutput("rx pulse timeout", rxPulses >= target, 1);
   endtask

   task automatic waitIdle();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (busyO === 1'b0) break;
      end
      checkOutput("idle timeout", busyO, 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] simulation hung");
   end

   logic expA5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic exp81 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int acc, r0, s0, c0, l0;
      logic qb;

      // Reset values while reset is held.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset cs_n", csNO, 1);
      checkOutput("reset sclk", sclkO, 0);
      checkOutput("reset mode", modeO, 0);
      checkOutput("reset ready", rdy, 0);
      checkOutput("reset busy", busyO, 0);
      checkOutput("reset rx_valid", rxValidO, 0);
      checkOutput("reset rx_data", rxDataO, 0);
      checkOutput("reset oe_n", oeNO, 1);
      @(posedge clk); #2;
      rst = 1'b0;

      // A5 LSB-first against a 3C MISO pattern.
      loopback = 1'b0; misoPattern = 8'h3C; mosiQ.delete(); r0 = rxPulses;
      applyStimulus(8'hA5, 1'b1, 1'b0, acc);
      waitRx(r0 + 1, 200);
      checkOutput("A5 rx offset", lastRxCyc - acc, 71);
      checkOutput("A5 rx data", lastRxData, 8'h3C);
      checkOutput("A5 mosi count", mosiQ.size(), 8);
      for (int i = 0; i < 8; i++) begin
         qb = (i < mosiQ.size()) ? mosiQ[i] : 1'bx;
         checkOutput($sformatf("A5 mosi bit %0d", i), qb, expA5[i]);
      end
      waitIdle();

      // 81 MSB-first against a C3 MISO pattern.
      misoPattern = 8'hC3; mosiQ.delete(); r0 = rxPulses;
      applyStimulus(8'h81, 1'b0, 1'b0, acc);
      waitRx(r0 + 1, 200);
      checkOutput("81 rx offset", lastRxCyc - acc, 71);
      checkOutput("81 rx data", lastRxData, 8'hC3);
      for (int i = 0; i < 8; i++) begin
         qb = (i < mosiQ.size()) ? mosiQ[i] : 1'bx;
         checkOutput($sformatf("81 mosi bit %0d", i), qb, exp81[i]);
      end
      waitIdle();
      loopback = 1'b1;

`ifdef SPI_BURST_EN
      // Two bytes back to back under one chip select.
      s0 = slowPulses; r0 = rxPulses;
      applyStimulus(8'h01, 1'b1, 1'b1, acc);
      txData = 8'h02;
      @(posedge clk); #2;
      c0 = csHighCycles;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (rdy === 1'b1) break;
      end
      @(posedge clk); #2;
      txValid = 1'b0;
      waitRx(r0 + 2, 300);
      checkOutput("burst slow pulses", slowPulses - s0, 16);
      checkOutput("burst rx pulses", rxPulses - r0, 2);
      checkOutput("burst cs_n high cycles", csHighCycles - c0, 0);
      checkOutput("burst second rx data", lastRxData, 8'h02);
      waitIdle();
`else
      // Valid held high: one accept per transfer and CS released between bytes.
      l0 = loads; r0 = rxPulses;
      applyStimulus(8'h5A, 1'b0, 1'b1, acc);
      waitRx(r0 + 1, 200);
      checkOutput("held valid single accept", loads - l0, 1);
      c0 = csHighCycles;
      for (int n = 0; n < 100 && (loads - l0) < 2; n++) @(posedge clk);
      checkOutput("held valid second accept", loads - l0, 2);
      checkOutput("cs_n high between bytes", (csHighCycles - c0) >= 1, 1);
      #2;
      txValid = 1'b0;
      waitIdle();
`endif

      // Reset for 16 cycles in the middle of SHIFT aborts the transfer.
      applyStimulus(8'hA5, 1'b1, 1'b0, acc);
      repeat (30) @(posedge clk);
      #2;
      rst = 1'b1;
      r0  = rxPulses;
      repeat (16) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post-reset ready", rdy, 1);
      checkOutput("post-reset cs_n", csNO, 1);
      checkOutput("post-reset sclk", sclkO, 0);
      repeat (100) @(posedge clk);
      checkOutput("no rx after abort", rxPulses - r0, 0);

      // Random bytes and bit orders with MOSI looped back to MISO.
      r0 = rxPulses;
      for (int i = 0; i < 100; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         applyStimulus(8'($urandom), 1'($urandom), 1'b0, acc);
      end
      waitRx(r0 + 100, 3000);
      checkOutput("random rx count", rxPulses - r0, 100);
      waitIdle();

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
